// File: rtl/data_upload.sv
// data_upload: streams a block of SDRAM bytes out over an SPI slave port.
// A small prefetch FIFO decouples the memory arbiter from the SPI timing.
module data_upload #(
    parameter int ADDR_W = 25,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              uploading,
    output logic              done,
    output logic              underrun,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [7:0]        mem_din,
    input  logic              sck,
    input  logic              ss,
    output logic              sdo,
    output logic              sdo_oe
);

    localparam int PW = $clog2(FIFO_D);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr, len, fetch_rem, sent_cnt, mem_addr_q;
    logic              mem_rd_q, stale, ack_q, done_q, done_nxt;
    logic              issue, take, acc;
    logic [7:0]        din_q;

    logic [7:0]        fifo_mem [FIFO_D];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic              full, empty, push, pop;

    logic [2:0]        sck_sy, ss_sy;
    logic              sck_rise, sck_fall, ss_rise, ss_fall, ss_act;

    logic [7:0]        shreg, cur_byte, nxt_byte;
    logic [2:0]        bit_cnt;
    logic              byte_valid, load_pend, nxt_valid;
    logic              load, reload, udr_set, underrun_q;

    assign acc   = mem_ack && mem_rd_q;
    assign full  = (count == (PW+1)'(FIFO_D));
    assign empty = (count == '0);
    assign push  = ack_q;

    assign sck_rise = sck_sy[1] & ~sck_sy[2];
    assign sck_fall = ~sck_sy[1] & sck_sy[2];
    assign ss_rise  = ss_sy[1] & ~ss_sy[2];
    assign ss_fall  = ~ss_sy[1] & ss_sy[2];
    assign ss_act   = ~ss_sy[1];

    assign uploading = (state != IDLE);
    assign done      = done_q;
    assign underrun  = underrun_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign sdo       = shreg[7];
    assign sdo_oe    = ss_act;

    // Fetch FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Fetch FSM next state; a start always wins and restarts the transfer
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        take      = 1'b0;
        done_nxt  = 1'b0;
        if (start) begin
            state_nxt = (length != '0) ? REQ : IDLE;
            done_nxt  = (length == '0);
        end else begin
            unique case (state)
                IDLE: ;
                REQ: begin
                    if (!mem_rd_q && !ack_q && !full) begin
                        issue     = 1'b1;
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (acc && !stale) begin
                        take      = 1'b1;
                        state_nxt = (fetch_rem == ADDR_W'(1)) ? DRAIN : REQ;
                    end
                end
                DRAIN: begin
                    if (sent_cnt == len) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    // Read request/address registers; a read cut short by an abort stays
    // held until its ack arrives, and that ack is then thrown away
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr       <= '0;
            len        <= '0;
            fetch_rem  <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            stale      <= 1'b0;
            ack_q      <= 1'b0;
            din_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= done_nxt;
            if (start) begin
                addr      <= start_addr;
                len       <= length;
                fetch_rem <= length;
                ack_q     <= 1'b0;
                stale     <= mem_rd_q && !mem_ack;
                mem_rd_q  <= mem_rd_q && !mem_ack;
            end else begin
                ack_q <= take;
                if (take) begin
                    din_q     <= mem_din;
                    addr      <= addr + ADDR_W'(1);
                    fetch_rem <= fetch_rem - ADDR_W'(1);
                    mem_rd_q  <= 1'b0;
                end else if (acc && stale) begin
                    stale    <= 1'b0;
                    mem_rd_q <= 1'b0;
                end else if (issue) begin
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= addr;
                end
            end
        end
    end

    // Prefetch FIFO; start flushes it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_D; i++) fifo_mem[i] <= '0;
        end else if (start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= din_q;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sy <= 3'b000;
            ss_sy  <= 3'b111;
        end else begin
            sck_sy <= {sck_sy[1:0], sck};
            ss_sy  <= {ss_sy[1:0], ss};
        end
    end

    // Next byte to present: FIFO head, filler 0xFF on underrun, else 0x00
    always_comb begin
        load      = 1'b0;
        reload    = 1'b0;
        nxt_byte  = 8'h00;
        nxt_valid = 1'b0;
        udr_set   = 1'b0;
        if (ss_fall) begin
            if (byte_valid) reload = 1'b1;
            else            load   = 1'b1;
        end else if (ss_act && sck_fall && load_pend) begin
            load = 1'b1;
        end
        pop = load && !start && !empty && (sent_cnt < len);
        if (pop) begin
            nxt_byte  = fifo_mem[rd_ptr];
            nxt_valid = 1'b1;
        end else if (load && state != IDLE && sent_cnt < len) begin
            nxt_byte = 8'hFF;
            udr_set  = 1'b1;
        end
    end

    // SPI mode-0 shifter; a byte counts as sent only after its 8th rising edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg      <= '0;
            cur_byte   <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
            load_pend  <= 1'b0;
            sent_cnt   <= '0;
            underrun_q <= 1'b0;
        end else begin
            if (ss_rise) begin
                bit_cnt   <= '0;
                load_pend <= 1'b0;
            end else if (reload) begin
                shreg     <= cur_byte;
                bit_cnt   <= '0;
                load_pend <= 1'b0;
            end else if (load) begin
                shreg      <= nxt_byte;
                cur_byte   <= nxt_byte;
                byte_valid <= nxt_valid;
                bit_cnt    <= '0;
                load_pend  <= 1'b0;
            end else if (ss_act && sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    load_pend <= 1'b1;
                    if (byte_valid) begin
                        sent_cnt   <= sent_cnt + ADDR_W'(1);
                        byte_valid <= 1'b0;
                    end
                end
            end else if (ss_act && sck_fall) begin
                shreg <= {shreg[6:0], 1'b0};
            end
            if (udr_set) underrun_q <= 1'b1;
            if (start) begin
                sent_cnt   <= '0;
                byte_valid <= 1'b0;
                underrun_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_upload.sv
// tb_data_upload: directed bench for data_upload with a simple
// SDRAM arbiter model and an SPI host driving sck/ss.
module tb_data_upload;

    localparam int AW   = 25;
    localparam int HALF = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] length;
    logic          uploading;
    logic          done;
    logic          underrun;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_ack;
    logic [7:0]    mem_din;
    logic          sck;
    logic          ss;
    logic          sdo;
    logic          sdo_oe;

    logic          ack_model = 1'b0;
    logic          ack_stray = 1'b0;
    logic [7:0]    din_model = 8'h00;

    assign mem_ack = ack_model | ack_stray;
    assign mem_din = ack_stray ? 8'h99 : din_model;

    data_upload #(.ADDR_W(AW), .FIFO_D(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .uploading  (uploading),
        .done       (done),
        .underrun   (underrun),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_ack    (mem_ack),
        .mem_din    (mem_din),
        .sck        (sck),
        .ss         (ss),
        .sdo        (sdo),
        .sdo_oe     (sdo_oe)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arbiter model: ack ack_dly cycles after mem_rd seen, data from pat
    int            ack_dly = 2;
    int            wcnt = 0;
    logic [AW-1:0] mem_base = '0;
    logic [7:0]    pat [8];
    logic [AW-1:0] rsp_off;
    logic [AW-1:0] addr_log [$];

    initial begin
        for (int i = 0; i < 8; i++) pat[i] = 8'h00;
        forever begin
            @(negedge clk);
            ack_model = 1'b0;
            if (mem_rd) begin
                if (wcnt >= ack_dly) begin
                    rsp_off   = mem_addr - mem_base;
                    din_model = pat[rsp_off[2:0]];
                    ack_model = 1'b1;
                    addr_log.push_back(mem_addr);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    int done_cnt = 0;
    int rd_cnt   = 0;

    always @(negedge clk) begin
        if (done)   done_cnt++;
        if (mem_rd) rd_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [AW-1:0] a, input logic [AW-1:0] l);
        start_addr = a;
        length     = l;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic spi_bits(input int n, output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < n; i++) begin
            repeat (HALF) @(negedge clk);
            b   = {b[6:0], sdo};
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic wait_rd(input string tag);
        for (int i = 0; i < 500 && !mem_rd; i++) @(negedge clk);
        chk(tag, 32'(mem_rd), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    logic [7:0] b;
    int         d0, r0, lg;

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        sck        = 1'b0;
        ss         = 1'b1;
        tick(3);
        chk("rst_uploading", 32'(uploading), 32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_underrun",  32'(underrun),  32'd0);
        chk("rst_mem_rd",    32'(mem_rd),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_sdo",       32'(sdo),       32'd0);
        chk("rst_sdo_oe",    32'(sdo_oe),    32'd0);
        reset_n = 1'b1;
        tick(3);

        // basic 3-byte upload
        mem_base = 25'h1C000;
        pat      = '{8'h41, 8'h42, 8'h43, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ack_dly  = 2;
        lg       = addr_log.size();
        d0       = done_cnt;
        do_start(25'h1C000, 25'd3);
        chk("t1_uploading", 32'(uploading), 32'd1);
        tick(40);
        chk("t1_nreq",  32'(addr_log.size() - lg), 32'd3);
        chk("t1_addr0", 32'(addr_log[lg]),     32'h1C000);
        chk("t1_addr2", 32'(addr_log[lg + 2]), 32'h1C002);
        ss = 1'b0;
        tick(4);
        chk("t1_sdo_oe", 32'(sdo_oe), 32'd1);
        spi_bits(8, b);
        chk("t1_byte0", 32'(b), 32'h41);
        spi_bits(8, b);
        chk("t1_byte1", 32'(b), 32'h42);
        spi_bits(8, b);
        chk("t1_byte2", 32'(b), 32'h43);
        tick(4);
        ss = 1'b1;
        tick(8);
        chk("t1_done_cnt",  32'(done_cnt - d0), 32'd1);
        chk("t1_underrun",  32'(underrun),      32'd0);
        chk("t1_uploading_end", 32'(uploading), 32'd0);

        // zero-length start
        d0 = done_cnt;
        r0 = rd_cnt;
        start_addr = 25'h123;
        length     = '0;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        chk("t2_done",      32'(done),      32'd1);
        chk("t2_uploading", 32'(uploading), 32'd0);
        tick(1);
        chk("t2_done_low",  32'(done),      32'd0);
        tick(10);
        chk("t2_no_rd",     32'(rd_cnt - r0),   32'd0);
        chk("t2_one_done",  32'(done_cnt - d0), 32'd1);

        // ss raised mid-byte, byte re-sent
        mem_base = 25'h100;
        pat      = '{8'h5A, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        d0       = done_cnt;
        do_start(25'h100, 25'd2);
        tick(30);
        ss = 1'b0;
        spi_bits(4, b);
        chk("t3_half", 32'(b), 32'h05);
        tick(4);
        ss = 1'b1;
        tick(16);
        ss = 1'b0;
        spi_bits(8, b);
        chk("t3_resent", 32'(b), 32'h5A);
        chk("t3_no_done_yet", 32'(done_cnt - d0), 32'd0);
        spi_bits(8, b);
        chk("t3_byte1", 32'(b), 32'h3C);
        tick(4);
        ss = 1'b1;
        tick(8);
        chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

        // slow memory, underrun filler
        mem_base = 25'h200;
        pat      = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ack_dly  = 200;
        d0       = done_cnt;
        lg       = addr_log.size();
        do_start(25'h200, 25'd2);
        tick(2);
        ss = 1'b0;
        spi_bits(8, b);
        chk("t4_filler",   32'(b),        32'hFF);
        chk("t4_underrun", 32'(underrun), 32'd1);
        chk("t4_no_done",  32'(done_cnt - d0), 32'd0);
        tick(4);
        ss = 1'b1;
        tick(500);
        chk("t4_nreq", 32'(addr_log.size() - lg), 32'd2);
        ss = 1'b0;
        spi_bits(8, b);
        chk("t4_byte0", 32'(b), 32'h11);
        chk("t4_no_done_mid", 32'(done_cnt - d0), 32'd0);
        spi_bits(8, b);
        chk("t4_byte1", 32'(b), 32'h22);
        tick(4);
        ss = 1'b1;
        tick(8);
        chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t4_sticky",   32'(underrun),      32'd1);

        // address wrap
        mem_base = 25'h1FFFFFF;
        pat      = '{8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ack_dly  = 1;
        d0       = done_cnt;
        lg       = addr_log.size();
        do_start(25'h1FFFFFF, 25'd2);
        chk("t5_udr_clear", 32'(underrun), 32'd0);
        tick(20);
        chk("t5_addr0", 32'(addr_log[lg]),     32'h1FFFFFF);
        chk("t5_addr1", 32'(addr_log[lg + 1]), 32'h0);
        ss = 1'b0;
        spi_bits(8, b);
        chk("t5_byte0", 32'(b), 32'h77);
        spi_bits(8, b);
        chk("t5_byte1", 32'(b), 32'h88);
        tick(4);
        ss = 1'b1;
        tick(8);
        chk("t5_done_cnt", 32'(done_cnt - d0), 32'd1);

        // abort during an outstanding read
        mem_base = 25'h300;
        ack_dly  = 6;
        d0       = done_cnt;
        do_start(25'h300, 25'd4);
        wait_rd("t6_rd_a");
        tick(1);
        mem_base = 25'h405;
        pat      = '{8'hC1, 8'hC2, 8'h00, 8'hEE, 8'h00, 8'h00, 8'h00, 8'h00};
        do_start(25'h405, 25'd2);
        chk("t6_uploading", 32'(uploading), 32'd1);
        tick(60);
        ss = 1'b0;
        spi_bits(8, b);
        chk("t6_byte0", 32'(b), 32'hC1);
        spi_bits(8, b);
        chk("t6_byte1", 32'(b), 32'hC2);
        tick(4);
        ss = 1'b1;
        tick(8);
        chk("t6_done_cnt", 32'(done_cnt - d0), 32'd1);

        // reset mid-fetch, then a stray ack
        mem_base = 25'h500;
        ack_dly  = 3;
        d0       = done_cnt;
        do_start(25'h500, 25'd3);
        tick(10);
        reset_n = 1'b0;
        #1;
        chk("t7_rd_drop", 32'(mem_rd), 32'd0);
        @(negedge clk);
        chk("t7_uploading", 32'(uploading), 32'd0);
        chk("t7_done",      32'(done),      32'd0);
        chk("t7_underrun",  32'(underrun),  32'd0);
        chk("t7_mem_addr",  32'(mem_addr),  32'd0);
        chk("t7_sdo",       32'(sdo),       32'd0);
        chk("t7_sdo_oe",    32'(sdo_oe),    32'd0);
        reset_n = 1'b1;
        tick(2);
        ack_stray = 1'b1;
        @(negedge clk);
        ack_stray = 1'b0;
        tick(5);
        chk("t7_post_rd",        32'(mem_rd),    32'd0);
        chk("t7_post_uploading", 32'(uploading), 32'd0);
        chk("t7_post_done",      32'(done_cnt - d0), 32'd0);
        ss = 1'b0;
        spi_bits(8, b);
        chk("t7_idle_byte", 32'(b), 32'h00);
        tick(4);
        ss = 1'b1;
        tick(4);
        chk("t7_post_underrun", 32'(underrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_upload.md
DATA_UPLOAD -- requirements
Module: data_upload

Interface
REQ-001 Parameter ADDR_W, default 25, width of memory address and length.
REQ-002 Parameter FIFO_D, default 4, prefetch FIFO depth in bytes (power of 2, >=2).
REQ-003 clk  in  1  system clock; all state on its rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle pulse; latches start_addr and length, begins upload.
REQ-006 start_addr  in  ADDR_W  first memory byte address.
REQ-007 length  in  ADDR_W  bytes to send; 0 means no transfer.
REQ-008 uploading  out  1  high from accepted start until last byte fully shifted or abort.
REQ-009 done  out  1  one-cycle pulse at normal completion.
REQ-010 underrun  out  1  sticky; set when a byte slot found FIFO empty; cleared by start.
REQ-011 mem_addr  out  ADDR_W  read address to SDRAM arbiter.
REQ-012 mem_rd  out  1  read request, held until mem_ack.
REQ-013 mem_ack  in  1  one-cycle; mem_din valid this cycle.
REQ-014 mem_din  in  8  read data.
REQ-015 sck  in  1  SPI clock from IO controller (async).
REQ-016 ss  in  1  SPI select, active low (async).
REQ-017 sdo  out  1  SPI MISO data.
REQ-018 sdo_oe  out  1  high while ss synchronised low.

Function
REQ-019 sck and ss SHALL pass 2-FF synchronisers; edges detected on synchronised values; clk SHALL be >= 8x sck frequency.
REQ-020 SPI mode 0, MSB first: sdo SHALL change only after a synchronised sck falling edge or ss falling edge; host samples on rising edge.
REQ-021 Fetch FSM states IDLE, REQ, WAIT, DRAIN; IDLE->REQ on start with length!=0; start with length==0 SHALL pulse done next cycle, uploading stays low.
REQ-022 REQ: assert mem_rd with mem_addr = current address when FIFO not full; ->WAIT.
REQ-023 WAIT: on mem_ack push mem_din, increment address, decrement remaining-fetch count; ->REQ if remaining>0 else DRAIN.
REQ-024 DRAIN: wait until all length bytes shifted, then pulse done, ->IDLE.
REQ-025 At most one outstanding read; mem_rd SHALL deassert the cycle after mem_ack.
REQ-026 Shifter: on ss falling edge, or on sck falling edge completing bit 0, load next byte: FIFO head (pop) if non-empty and sent-count<length; else 0xFF with underrun set if transfer active and bytes remain; else 0x00 after completion.
REQ-027 Sent-count increments only when a popped byte has all 8 bits shifted (8th sck rising edge).
REQ-028 ss rising edge mid-byte: bit counter cleared; popped byte SHALL be retained and re-sent first at next ss falling edge; sent-count unchanged.
REQ-029 start while uploading SHALL abort: FIFO flushed, outstanding mem_ack discarded, new transfer latched; no done pulse for aborted transfer.
REQ-030 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-031 FIFO full: no mem_rd issued; FIFO push and pop same cycle SHALL both succeed, occupancy unchanged.
REQ-032 Fetch latency mem_rd to push: one cycle after mem_ack.

Reset
REQ-033 On reset_n low: FSM IDLE, FIFO empty, counters 0, uploading=0, done=0, underrun=0, mem_rd=0, mem_addr=0, sdo=0, sdo_oe=0.
REQ-034 Reset mid-transfer SHALL drop mem_rd immediately; a later mem_ack SHALL be ignored.

Verification
REQ-035 start_addr=0x1C000, length=3, memory 0x41,0x42,0x43, mem_ack 2 cycles after mem_rd, 24 sck -> sdo bits 01000001 01000010 01000011, done one pulse, underrun=0.
REQ-036 length=0 start -> done next cycle, mem_rd never asserted, uploading stays 0.
REQ-037 mem_ack delayed 200 cycles, fast sck -> first byte 0xFF, underrun=1, sent-count excludes 0xFF slot.
REQ-038 ss raised after 4 bits of byte 0x5A, lowered again -> full 0x5A re-sent, total bytes sent = length.
REQ-039 start_addr=2^25-1, length=2 -> mem_addr 0x1FFFFFF then 0x0000000.
REQ-040 Second start during transfer, then reset_n pulse mid-fetch -> FIFO empty, all outputs at REQ-033 values, stray mem_ack ignored.
